clock_datapath: RTL and testbench

Timekeeping and alarm datapath. It is the responder to the alarm-clock mode state machine: it consumes that FSM's adjust, EN and snooze controls plus the button pulses, and holds the time-of-day, alarm and snooze counters. It returns secs, the alarm-match flag Z and the snooze-expiry flag z_s to the FSM, and drives time/alarm fields to the display logic.

---
 rtl/clock_datapath.sv | 137 +++++++++++++
 tb/tb_clock_datapath.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_datapath.sv
// Time-of-day, alarm and snooze counters for the alarm-clock FSM.
// Optional macro ADJ_CARRY_EN: time-minute adjust carries/borrows into hours.
module clock_datapath #(
  parameter int unsigned SNOOZE_SECS    = 300,
  parameter int unsigned ALARM_RST_HOUR = 6,
  parameter int unsigned ALARM_RST_MIN  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       adjust,
  input  logic [4:0] EN,
  input  logic       up,
  input  logic       down,
  input  logic       snoozeEN,
  input  logic       snooze_rst,
  output logic [5:0] secs,
  output logic [5:0] mins,
  output logic [4:0] hours,
  output logic [5:0] alarm_min,
  output logic [4:0] alarm_hour,
  output logic       Z,
  output logic       z_s
);

  localparam logic [4:0] AlarmRstHour = 5'(ALARM_RST_HOUR);
  localparam logic [5:0] AlarmRstMin  = 6'(ALARM_RST_MIN);
  localparam logic [8:0] SnoozeSecs   = 9'(SNOOZE_SECS);

  logic [5:0] secs_q, secs_d;
  logic [5:0] mins_q, mins_d;
  logic [4:0] hours_q, hours_d;
  logic [5:0] alarm_min_q, alarm_min_d;
  logic [4:0] alarm_hour_q, alarm_hour_d;
  logic [8:0] snooze_cnt_q, snooze_cnt_d;
  logic       z_q, z_d;
  logic       z_s_q, z_s_d;
  logic       step;

  logic unused_en0;
  assign unused_en0 = EN[0];

  function automatic logic [5:0] step60(input logic [5:0] v, input logic dir_up);
    if (dir_up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    else        return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [4:0] step24(input logic [4:0] v, input logic dir_up);
    if (dir_up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
    else        return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  // Opposing pulses in the same cycle cancel out.
  assign step = up ^ down;

  always_comb begin
    secs_d       = secs_q;
    mins_d       = mins_q;
    hours_d      = hours_q;
    alarm_min_d  = alarm_min_q;
    alarm_hour_d = alarm_hour_q;

    if (!adjust) begin
      if (tick_1hz) begin
        if (secs_q == 6'd59) begin
          secs_d = 6'd0;
          if (mins_q == 6'd59) begin
            mins_d  = 6'd0;
            hours_d = step24(hours_q, 1'b1);
          end else begin
            mins_d = mins_q + 6'd1;
          end
        end else begin
          secs_d = secs_q + 6'd1;
        end
      end
    end else if (step) begin
      if (EN[4]) hours_d = step24(hours_q, up);
      if (EN[3]) begin
        mins_d = step60(mins_q, up);
`ifdef ADJ_CARRY_EN
        if ((up && mins_q == 6'd59) || (!up && mins_q == 6'd0)) begin
          hours_d = step24(hours_d, up);
        end
`endif
      end
      if (EN[4] || EN[3]) secs_d = 6'd0;
      if (EN[2]) alarm_hour_d = step24(alarm_hour_q, up);
      if (EN[1]) alarm_min_d = step60(alarm_min_q, up);
    end
  end

  always_comb begin
    snooze_cnt_d = snooze_cnt_q;
    z_s_d        = (snooze_cnt_q == SnoozeSecs);
    if (snooze_rst) begin
      snooze_cnt_d = 9'd0;
      z_s_d        = 1'b0;
    end else if (snoozeEN && tick_1hz && (snooze_cnt_q < SnoozeSecs)) begin
      snooze_cnt_d = snooze_cnt_q + 9'd1;
    end
  end

  // Compares current register values, so Z trails the counters by one cycle.
  assign z_d = (hours_q == alarm_hour_q) && (mins_q == alarm_min_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      secs_q       <= 6'd0;
      mins_q       <= 6'd0;
      hours_q      <= 5'd0;
      alarm_min_q  <= AlarmRstMin;
      alarm_hour_q <= AlarmRstHour;
      snooze_cnt_q <= 9'd0;
      z_q          <= 1'b0;
      z_s_q        <= 1'b0;
    end else begin
      secs_q       <= secs_d;
      mins_q       <= mins_d;
      hours_q      <= hours_d;
      alarm_min_q  <= alarm_min_d;
      alarm_hour_q <= alarm_hour_d;
      snooze_cnt_q <= snooze_cnt_d;
      z_q          <= z_d;
      z_s_q        <= z_s_d;
    end
  end

  assign secs       = secs_q;
  assign mins       = mins_q;
  assign hours      = hours_q;
  assign alarm_min  = alarm_min_q;
  assign alarm_hour = alarm_hour_q;
  assign Z          = z_q;
  assign z_s        = z_s_q;

endmodule

// File: tb/tb_clock_datapath.sv
// Directed bench for clock_datapath: expectations queued at stimulus, popped after the clock.
module tb_clock_datapath;

  logic       clk, rst, tick_1hz, adjust, up, down, snoozeEN, snooze_rst;
  logic [4:0] EN;
  logic [5:0] secs, mins, alarm_min;
  logic [4:0] hours, alarm_hour;
  logic       Z, z_s;

  typedef struct {
    string       tag;
    int          field;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   eh, em, es, ah, am;

  localparam int FSecs = 0, FMins = 1, FHours = 2, FAmin = 3, FAhour = 4, FZ = 5, FZs = 6;
`ifdef ADJ_CARRY_EN
  localparam int HUpSteps = 11;
`else
  localparam int HUpSteps = 10;
`endif

  clock_datapath #(
    .SNOOZE_SECS   (300),
    .ALARM_RST_HOUR(6),
    .ALARM_RST_MIN (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .adjust    (adjust),
    .EN        (EN),
    .up        (up),
    .down      (down),
    .snoozeEN  (snoozeEN),
    .snooze_rst(snooze_rst),
    .secs      (secs),
    .mins      (mins),
    .hours     (hours),
    .alarm_min (alarm_min),
    .alarm_hour(alarm_hour),
    .Z         (Z),
    .z_s       (z_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int f);
    case (f)
      FSecs:   return 32'(secs);
      FMins:   return 32'(mins);
      FHours:  return 32'(hours);
      FAmin:   return 32'(alarm_min);
      FAhour:  return 32'(alarm_hour);
      FZ:      return 32'(Z);
      default: return 32'(z_s);
    endcase
  endfunction

  task automatic push(input string tag, input int f, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.field = f;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_time(input string tag);
    push({tag, ".secs"}, FSecs, 32'(es));
    push({tag, ".mins"}, FMins, 32'(em));
    push({tag, ".hours"}, FHours, 32'(eh));
  endtask

  task automatic push_alarm(input string tag);
    push({tag, ".amin"}, FAmin, 32'(am));
    push({tag, ".ahour"}, FAhour, 32'(ah));
  endtask

  task automatic push_reset(input string tag);
    es = 0; em = 0; eh = 0; ah = 6; am = 0;
    push_time(tag);
    push_alarm(tag);
    push({tag, ".Z"}, FZ, 32'd0);
    push({tag, ".z_s"}, FZs, 32'd0);
  endtask

  task automatic check_q();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.field);
      checks++;
      assert (obs === e.val)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  // Reference 1 Hz time-of-day advance.
  task automatic adv();
    if (es == 59) begin
      es = 0;
      if (em == 59) begin
        em = 0;
        eh = (eh + 1) % 24;
      end else em++;
    end else es++;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    if (!adjust) adv();
    @(negedge clk);
    tick_1hz = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic step(input logic [4:0] en, input logic u, input logic d);
    EN = en;
    up = u;
    down = d;
    @(negedge clk);
    up = 1'b0;
    down = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; adjust = 1'b0; up = 1'b0; down = 1'b0;
    snoozeEN = 1'b0; snooze_rst = 1'b0; EN = 5'd0;

    // 1: reset state, then asynchronous reset mid-count
    repeat (2) @(negedge clk);
    push_reset("por");
    check_q();
    rst = 1'b0;
    tick_n(3);
    push_time("count3");
    check_q();
    #2 rst = 1'b1;
    #1 push_reset("midrst");
    check_q();
    @(negedge clk);
    rst = 1'b0;
    tick();
    push_time("post_rst_tick");
    check_q();

    // 2: preset 23:59:58 then wrap through midnight
    adjust = 1'b1;
    step(5'b01000, 1'b0, 1'b1);
    em = 59; es = 0;
`ifdef ADJ_CARRY_EN
    eh = 23;
`else
    step(5'b10000, 1'b0, 1'b1);
    eh = 23;
`endif
    push_time("preset");
    check_q();
    adjust = 1'b0;
    EN = 5'd0;
    tick_n(58);
    push_time("t235958");
    check_q();
    tick();
    push_time("t235959");
    check_q();
    tick();
    push_time("midnight");
    check_q();

    // 3: minute adjust wrap at 10:59:30
    adjust = 1'b1;
    step(5'b01000, 1'b0, 1'b1);
    em = 59; es = 0;
    for (int i = 0; i < HUpSteps; i++) step(5'b10000, 1'b1, 1'b0);
    eh = 10;
    adjust = 1'b0;
    EN = 5'd0;
    tick_n(30);
    push_time("t105930");
    check_q();
    adjust = 1'b1;
    step(5'b01000, 1'b1, 1'b0);
    em = 0; es = 0;
`ifdef ADJ_CARRY_EN
    eh = 11;
`else
    eh = 10;
`endif
    push_time("min_up_wrap");
    check_q();
    step(5'b01000, 1'b0, 1'b1);
    em = 59; eh = 10;
    push_time("min_down_wrap");
    check_q();

    // 4: alarm wraps and the Z match window
    step(5'b00010, 1'b0, 1'b1);
    am = 59;
    push_alarm("amin_down_wrap");
    check_q();
    step(5'b00010, 1'b1, 1'b0);
    am = 0;
    push_alarm("amin_up_wrap");
    check_q();
    for (int i = 0; i < 6; i++) step(5'b00100, 1'b0, 1'b1);
    ah = 0;
    push_alarm("ahour0");
    check_q();
    step(5'b00100, 1'b0, 1'b1);
    ah = 23;
    push_alarm("ahour_wrap");
    check_q();
    for (int i = 0; i < 8; i++) step(5'b00100, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step(5'b00010, 1'b1, 1'b0);
    ah = 7; am = 30;
    push_alarm("alarm0730");
    check_q();
    for (int i = 0; i < 30; i++) step(5'b01000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(5'b10000, 1'b0, 1'b1);
    eh = 7; em = 29; es = 0;
    adjust = 1'b0;
    EN = 5'd0;
    tick_n(59);
    push_time("t072959");
    push("z_before", FZ, 32'd0);
    check_q();
    tick();
    push_time("t073000");
    push("z_lag_on", FZ, 32'd0);
    check_q();
    @(negedge clk);
    push("z_on", FZ, 32'd1);
    check_q();
    tick_n(60);
    push_time("t073100");
    push("z_lag_off", FZ, 32'd1);
    check_q();
    @(negedge clk);
    push("z_off", FZ, 32'd0);
    check_q();

    // 5: snooze count, saturation and clear
    snoozeEN = 1'b1;
    tick_n(299);
    push("zs_299", FZs, 32'd0);
    check_q();
    tick();
    push("zs_lag", FZs, 32'd0);
    check_q();
    @(negedge clk);
    push("zs_set", FZs, 32'd1);
    check_q();
    tick_n(5);
    push("zs_saturated", FZs, 32'd1);
    push_time("t_after_snooze");
    check_q();
    snooze_rst = 1'b1;
    @(negedge clk);
    snooze_rst = 1'b0;
    push("zs_clear", FZs, 32'd0);
    check_q();
    @(negedge clk);
    push("zs_stays_clear", FZs, 32'd0);
    check_q();
    snoozeEN = 1'b0;

    // 6: adjust freezes time; cancelled and multi-field steps
    adjust = 1'b1;
    EN = 5'b11110;
    tick_n(3);
    push_time("adj_frozen");
    check_q();
    step(5'b11110, 1'b1, 1'b1);
    push_time("updown_nochange");
    push_alarm("updown_nochange");
    check_q();
    step(5'b00000, 1'b1, 1'b0);
    push_time("en0_nochange");
    push_alarm("en0_nochange");
    check_q();
    step(5'b11110, 1'b1, 1'b0);
    eh = (eh + 1) % 24; em = (em + 1) % 60; es = 0;
    ah = (ah + 1) % 24; am = (am + 1) % 60;
    push_time("multi_step");
    push_alarm("multi_step");
    check_q();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
